// File: rtl/key_conditioner.sv
// Button conditioner: polarity fix, two-flop synchroniser and per-key debounce FSM.
// Produces clean key levels plus one-cycle press/release strobes for game_logic.
module key_conditioner #(
   parameter int KEYS_W          = 3,
   parameter int BOARD_CLK_MHZ   = 25,
   parameter int DEBOUNCE_US     = 10000,
   parameter int ACTIVE_LOW_KEYS = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [KEYS_W-1:0] keys_raw_i,
   output logic [KEYS_W-1:0] keys_o,
   output logic [KEYS_W-1:0] press_o,
   output logic [KEYS_W-1:0] release_o,
   output logic              any_key_o
);

   localparam int DB_CYCLES = BOARD_CLK_MHZ * DEBOUNCE_US;
   localparam int CNT_W     = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   if (DB_CYCLES < 2) begin : g_db_check
      $error("key_conditioner: DB_CYCLES must be at least 2");
   end

   typedef enum logic {STABLE, CHECK} state_e;

   state_e            state_q [KEYS_W];
   state_e            state_d [KEYS_W];
   logic [CNT_W-1:0]  cnt_q   [KEYS_W];
   logic [CNT_W-1:0]  cnt_d   [KEYS_W];

   logic [KEYS_W-1:0] pressed_raw;
   logic [KEYS_W-1:0] sync1_q, sync2_q;
   logic [KEYS_W-1:0] keys_q, keys_d;
   logic [KEYS_W-1:0] press_q, press_d;
   logic [KEYS_W-1:0] release_q, release_d;
   logic              any_q;
   logic [KEYS_W-1:0] diff;
   logic [KEYS_W-1:0] done;

   // Polarity is fixed before the synchroniser so both flops see "1 = pressed".
   assign pressed_raw = (ACTIVE_LOW_KEYS != 0) ? ~keys_raw_i : keys_raw_i;
   assign diff        = sync2_q ^ keys_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         keys_q    <= '0;
         press_q   <= '0;
         release_q <= '0;
         any_q     <= 1'b0;
         for (int k = 0; k < KEYS_W; k++) begin
            state_q[k] <= STABLE;
            cnt_q[k]   <= '0;
         end
      end else begin
         sync1_q   <= pressed_raw;
         sync2_q   <= sync1_q;
         keys_q    <= keys_d;
         press_q   <= press_d;
         release_q <= release_d;
         any_q     <= |keys_d;
         for (int k = 0; k < KEYS_W; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   // A key completes its debounce when the last counted edge still disagrees.
   always_comb begin
      done = '0;
      for (int k = 0; k < KEYS_W; k++) begin
         done[k] = (state_q[k] == CHECK) && diff[k] && (cnt_q[k] == CNT_LAST);
      end
   end

   always_comb begin
      for (int k = 0; k < KEYS_W; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         case (state_q[k])
            STABLE: begin
               if (diff[k]) begin
                  state_d[k] = CHECK;
                  cnt_d[k]   = CNT_W'(1);
               end else begin
                  cnt_d[k]   = '0;
               end
            end
            CHECK: begin
               if (!diff[k] || done[k]) begin
                  state_d[k] = STABLE;
                  cnt_d[k]   = '0;
               end else begin
                  cnt_d[k]   = cnt_q[k] + CNT_W'(1);
               end
            end
            default: begin
               state_d[k] = STABLE;
               cnt_d[k]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      keys_d    = keys_q ^ done;
      press_d   = done & ~keys_q;
      release_d = done & keys_q;
   end

   assign keys_o    = keys_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign any_key_o = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DB_CYCLES=4, three active-low keys.
// A per-edge vector table covers press/bounce/glitch/release; resets are hand-written.
module tb_key_conditioner;

   localparam int KEYS_W = 3;

   logic              clk;
   logic              rst_n;
   logic [KEYS_W-1:0] rawKeys;
   logic [KEYS_W-1:0] keysOut;
   logic [KEYS_W-1:0] pressOut;
   logic [KEYS_W-1:0] releaseOut;
   logic              anyKey;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [KEYS_W-1:0] raw;
      logic [KEYS_W-1:0] keys;
      logic [KEYS_W-1:0] press;
      logic [KEYS_W-1:0] rel;
      logic              any;
   } vec_t;

   vec_t vecs[$];

   key_conditioner #(
      .KEYS_W          (KEYS_W),
      .BOARD_CLK_MHZ   (1),
      .DEBOUNCE_US     (4),
      .ACTIVE_LOW_KEYS (1)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .keys_raw_i (rawKeys),
      .keys_o     (keysOut),
      .press_o    (pressOut),
      .release_o  (releaseOut),
      .any_key_o  (anyKey)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a stuck run still ends with a report.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, got running, want finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [KEYS_W-1:0] raw);
      rawKeys = raw;
   endtask

   task automatic checkOutput(input string name, input logic [KEYS_W-1:0] act,
                              input logic [KEYS_W-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [KEYS_W-1:0] eKeys,
                           input logic [KEYS_W-1:0] ePress, input logic [KEYS_W-1:0] eRel,
                           input logic eAny);
      checkOutput({tag, ".keys"},    keysOut,    eKeys);
      checkOutput({tag, ".press"},   pressOut,   ePress);
      checkOutput({tag, ".release"}, releaseOut, eRel);
      checkOutput({tag, ".any"},     {{(KEYS_W-1){1'b0}}, anyKey}, {{(KEYS_W-1){1'b0}}, eAny});
   endtask

   task automatic addVec(input int n, input logic [KEYS_W-1:0] raw, input logic [KEYS_W-1:0] k,
                         input logic [KEYS_W-1:0] p, input logic [KEYS_W-1:0] r, input logic a);
      vec_t v;
      v.raw = raw; v.keys = k; v.press = p; v.rel = r; v.any = a;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   initial begin
      // Clean press on key 0: strobe on the 6th edge only.
      addVec(5, 3'b110, 3'b000, 3'b000, 3'b000, 1'b0);
      addVec(1, 3'b110, 3'b001, 3'b001, 3'b000, 1'b1);
      addVec(1, 3'b110, 3'b001, 3'b000, 3'b000, 1'b1);
      // Bounce on key 1: 0,1,0,1 then settles low; press 6 edges after settle.
      addVec(1, 3'b100, 3'b001, 3'b000, 3'b000, 1'b1);
      addVec(1, 3'b110, 3'b001, 3'b000, 3'b000, 1'b1);
      addVec(1, 3'b100, 3'b001, 3'b000, 3'b000, 1'b1);
      addVec(1, 3'b110, 3'b001, 3'b000, 3'b000, 1'b1);
      addVec(5, 3'b100, 3'b001, 3'b000, 3'b000, 1'b1);
      addVec(1, 3'b100, 3'b011, 3'b010, 3'b000, 1'b1);
      addVec(1, 3'b100, 3'b011, 3'b000, 3'b000, 1'b1);
      // Three-cycle glitch on key 2 never gets through.
      addVec(3, 3'b000, 3'b011, 3'b000, 3'b000, 1'b1);
      addVec(5, 3'b100, 3'b011, 3'b000, 3'b000, 1'b1);
      // Simultaneous release of keys 0 and 1.
      addVec(5, 3'b111, 3'b011, 3'b000, 3'b000, 1'b1);
      addVec(1, 3'b111, 3'b000, 3'b000, 3'b011, 1'b0);
      addVec(1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);

      // Power-on reset with every key held down.
      applyStimulus(3'b000);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 checkAll("rst_async", 3'b000, 3'b000, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkAll($sformatf("rst_hold%0d", i), 3'b000, 3'b000, 3'b000, 1'b0);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e < 6)       checkAll($sformatf("rst_rel_e%0d", e), 3'b000, 3'b000, 3'b000, 1'b0);
         else if (e == 6) checkAll("rst_rel_e6", 3'b111, 3'b111, 3'b000, 1'b1);
         else             checkAll("rst_rel_e7", 3'b111, 3'b000, 3'b000, 1'b1);
      end

      // Let go of all three keys to reach an idle baseline.
      applyStimulus(3'b111);
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e < 6)       checkAll($sformatf("idle_e%0d", e), 3'b111, 3'b000, 3'b000, 1'b1);
         else if (e == 6) checkAll("idle_e6", 3'b000, 3'b000, 3'b111, 1'b0);
         else             checkAll("idle_e7", 3'b000, 3'b000, 3'b000, 1'b0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].raw);
         tick();
         checkAll($sformatf("vec%0d", i), vecs[i].keys, vecs[i].press, vecs[i].rel, vecs[i].any);
      end

      // Key 1 debounced, then key 0 pressed and reset hits while key 0 has c=2.
      applyStimulus(3'b101);
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e < 6)       checkAll($sformatf("mid_k1_e%0d", e), 3'b000, 3'b000, 3'b000, 1'b0);
         else if (e == 6) checkAll("mid_k1_e6", 3'b010, 3'b010, 3'b000, 1'b1);
         else             checkAll("mid_k1_e7", 3'b010, 3'b000, 3'b000, 1'b1);
      end
      applyStimulus(3'b100);
      for (int e = 1; e <= 4; e++) begin
         tick();
         checkAll($sformatf("mid_k0_e%0d", e), 3'b010, 3'b000, 3'b000, 1'b1);
      end
      rst_n = 1'b0;
      #1 checkAll("mid_rst_async", 3'b000, 3'b000, 3'b000, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkAll($sformatf("mid_rst_hold%0d", i), 3'b000, 3'b000, 3'b000, 1'b0);
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e < 6)       checkAll($sformatf("mid_rel_e%0d", e), 3'b000, 3'b000, 3'b000, 1'b0);
         else if (e == 6) checkAll("mid_rel_e6", 3'b011, 3'b011, 3'b000, 1'b1);
         else             checkAll("mid_rel_e7", 3'b011, 3'b000, 3'b000, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
